// File: rtl/exec_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the execute-stage multiply/divide unit:
//   - md_op_e    : encodings of the md_op command field
//   - md_state_e : iteration FSM states
//   - DEFAULT_DATA_W : operand / HI / LO width used by the 32-bit core
// -----------------------------------------------------------------------------
package exec_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIX  = 2'b11
  } md_state_e;

endpackage

// File: rtl/md_div_step.sv
// -----------------------------------------------------------------------------
// md_div_step
// One combinational restoring-division step on unsigned magnitudes.
// The partial remainder is shifted left by one, pulling in the next dividend
// bit from the top of the quotient register; if the divisor fits, it is
// subtracted and a 1 enters the quotient, otherwise the shifted remainder is
// kept and a 0 enters the quotient.
// Ports:
//   rem_in  / quo_in  : current partial remainder / dividend-quotient register
//   divisor           : unsigned divisor magnitude
//   rem_out / quo_out : values after this step
// -----------------------------------------------------------------------------
module md_div_step
  import exec_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] quo_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] quo_out
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  always_comb begin
    // The remainder is always below the divisor, so the shifted value fits in
    // DATA_W+1 bits and a borrow out of the top bit means "does not fit".
    shifted = {rem_in, quo_in[DATA_W-1]};
    diff    = shifted - {1'b0, divisor};
    if (diff[DATA_W]) begin
      rem_out = shifted[DATA_W-1:0];
      quo_out = {quo_in[DATA_W-2:0], 1'b0};
    end else begin
      rem_out = diff[DATA_W-1:0];
      quo_out = {quo_in[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/exec_muldiv_unit.sv
// -----------------------------------------------------------------------------
// exec_muldiv_unit
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Executes MULT, MULTU, DIV, DIVU (one bit per cycle) and MTHI/MTLO.
// Operations work on unsigned magnitudes; signs are applied in the FIX state.
//
// Optional build macro:
//   MULDIV_EARLY_OUT_EN : multiply terminates as soon as no multiplier bits
//                         remain set (variable latency, identical results).
//
// Ports:
//   clock        : rising-edge clock
//   reset_n      : asynchronous active-low reset
//   start        : operation request, sampled only while busy is low
//   md_op        : MULT/MULTU/DIV/DIVU/MTHI/MTLO, other codes are NOP
//   rs_data      : dividend / multiplicand / MTHI-MTLO source
//   rt_data      : divisor / multiplier
//   flush        : kill in-flight operation, also blocks a same-cycle start
//   busy         : iteration in progress (MUL, DIV or FIX)
//   done         : one-cycle pulse when HI/LO take a mult/div result
//   div_by_zero  : set with done when a divide had a zero divisor
//   hi, lo       : HI and LO registers
// -----------------------------------------------------------------------------
module exec_muldiv_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        md_op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Two's-complement magnitude; the most-negative value maps to 2^(W-1),
  // which is exactly representable as an unsigned magnitude.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                  input logic                     is_signed);
    magnitude = (is_signed && v[DATA_W-1]) ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                   input logic              negate);
    apply_sign = negate ? -v : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] apply_sign_wide(input logic [2*DATA_W-1:0] v,
                                                          input logic                negate);
    apply_sign_wide = negate ? -v : v;
  endfunction

  // Control state (asynchronously reset)
  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;
  logic              dbz_pend_q, dbz_pend_d;
  logic              is_div_q, is_div_d;
  logic              neg_q, neg_d;        // negate product / quotient
  logic              rneg_q, rneg_d;      // negate remainder
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  // Datapath state (no reset needed; always loaded before use).
  // acc holds the product for multiply and {remainder, quotient} for divide;
  // mcand holds the left-shifting multiplicand or, in its low half, the divisor.
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplr_q, mplr_d;

  logic                op_signed;
  logic [DATA_W-1:0]   rs_mag;
  logic [DATA_W-1:0]   rt_mag;
  logic [2*DATA_W-1:0] mul_sum;
  logic [DATA_W-1:0]   div_rem;
  logic [DATA_W-1:0]   div_quo;

  md_div_step #(
    .DATA_W (DATA_W)
  ) u_div_step (
    .rem_in  (acc_q[2*DATA_W-1:DATA_W]),
    .quo_in  (acc_q[DATA_W-1:0]),
    .divisor (mcand_q[DATA_W-1:0]),
    .rem_out (div_rem),
    .quo_out (div_quo)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    dbz_pend_d = dbz_pend_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplr_d     = mplr_q;

    op_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
    rs_mag    = magnitude(rs_data, op_signed);
    rt_mag    = magnitude(rt_data, op_signed);
    mul_sum   = acc_q + (mplr_q[0] ? mcand_q : '0);

    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          dbz_d = 1'b0;
          case (md_op)
            MD_MULT, MD_MULTU: begin
              is_div_d   = 1'b0;
              dbz_pend_d = 1'b0;
              neg_d      = op_signed & (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
              rneg_d     = 1'b0;
              acc_d      = '0;
              mcand_d    = {{DATA_W{1'b0}}, rs_mag};
              mplr_d     = rt_mag;
              cnt_d      = CNT_LOAD;
              busy_d     = 1'b1;
              state_d    = ST_MUL;
`ifdef MULDIV_EARLY_OUT_EN
              if (rt_mag == '0) begin
                state_d = ST_FIX;
              end
`endif
            end
            MD_DIV, MD_DIVU: begin
              is_div_d = 1'b1;
              busy_d   = 1'b1;
              if (rt_data == '0) begin
                // Preload the architected zero-divisor result and finish in FIX.
                dbz_pend_d = 1'b1;
                neg_d      = 1'b0;
                rneg_d     = 1'b0;
                acc_d      = {rs_data, {DATA_W{1'b1}}};
                cnt_d      = '0;
                state_d    = ST_FIX;
              end else begin
                dbz_pend_d = 1'b0;
                neg_d      = op_signed & (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
                rneg_d     = op_signed & rs_data[DATA_W-1];
                acc_d      = {{DATA_W{1'b0}}, rs_mag};
                mcand_d    = {{DATA_W{1'b0}}, rt_mag};
                cnt_d      = CNT_LOAD;
                state_d    = ST_DIV;
              end
            end
            MD_MTHI: hi_d = rs_data;
            MD_MTLO: lo_d = rs_data;
            default: ;
          endcase
        end
      end

      ST_MUL: begin
        if (flush) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          acc_d   = mul_sum;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_FIX;
          end
`ifdef MULDIV_EARLY_OUT_EN
          if (mplr_d == '0) begin
            state_d = ST_FIX;
          end
`endif
        end
      end

      ST_DIV: begin
        if (flush) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          acc_d = {div_rem, div_quo};
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_FIX;
          end
        end
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
        if (!flush) begin
          done_d = 1'b1;
          dbz_d  = dbz_pend_q;
          if (is_div_q) begin
            hi_d = apply_sign(acc_q[2*DATA_W-1:DATA_W], rneg_q);
            lo_d = apply_sign(acc_q[DATA_W-1:0], neg_q);
          end else begin
            {hi_d, lo_d} = apply_sign_wide(acc_q, neg_q);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM and architectural registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      dbz_pend_q <= 1'b0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      dbz_pend_q <= dbz_pend_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  // Iteration datapath
  always_ff @(posedge clock) begin
    acc_q   <= acc_d;
    mcand_q <= mcand_d;
    mplr_q  <= mplr_d;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_exec_muldiv_unit.sv
module tb_exec_muldiv_unit;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int lat;
  int bcnt;
  int ovl;
  int dcnt;

  exec_muldiv_unit #(.DATA_W(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .md_op       (md_op),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the
  // edge on which done is seen. lat counts the start edge as edge 1.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op = op; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; md_op = 3'b111;
    lat = 1; bcnt = busy ? 1 : 0; ovl = 0;
    while (!done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
      if (busy) bcnt++;
      if (busy && done) ovl++;
    end
    chk("op_done_seen", {63'd0, done}, 64'd1);
  endtask

  task automatic write_reg(input logic [2:0] op, input logic [31:0] a);
    md_op = op; rs_data = a; rt_data = 32'd0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; md_op = 3'b111;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; md_op = 3'b111;
    rs_data = '0; rt_data = '0; flush = 1'b0;
    #2;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // MULT -3 * 7 = -21
    run_op(3'b000, 32'hFFFF_FFFD, 32'd7);
`ifndef MULDIV_EARLY_OUT_EN
    chk("mult_latency", 64'(lat), 64'd34);
    chk("mult_busy_cycles", 64'(bcnt), 64'd33);
`endif
    chk("mult_overlap", 64'(ovl), 64'd0);
    chk("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    chk("mult_lo", {32'd0, lo}, 64'hFFFF_FFEB);
    chk("mult_dbz", {63'd0, div_by_zero}, 64'd0);
    @(posedge clock); #1;
    chk("done_pulse", {63'd0, done}, 64'd0);

    // MULTU max * max
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_hi", {32'd0, hi}, 64'hFFFF_FFFE);
    chk("multu_lo", {32'd0, lo}, 64'h0000_0001);

    // DIV -7 / 2 : q=-3, r=-1
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2);
`ifndef MULDIV_EARLY_OUT_EN
    chk("div_latency", 64'(lat), 64'd34);
`endif
    chk("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
    chk("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);

    // DIV 7 / -2 : q=-3, r=+1
    run_op(3'b010, 32'd7, 32'hFFFF_FFFE);
    chk("div2_lo", {32'd0, lo}, 64'hFFFF_FFFD);
    chk("div2_hi", {32'd0, hi}, 64'd1);

    // DIV most-negative / -1 wraps
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("divmin_lo", {32'd0, lo}, 64'h8000_0000);
    chk("divmin_hi", {32'd0, hi}, 64'd0);
    chk("divmin_dbz", {63'd0, div_by_zero}, 64'd0);

    // DIVU treats operands as unsigned
    run_op(3'b011, 32'hFFFF_FFFF, 32'h10);
    chk("divu_lo", {32'd0, lo}, 64'h0FFF_FFFF);
    chk("divu_hi", {32'd0, hi}, 64'hF);

    // DIVU by zero
    run_op(3'b011, 32'd100, 32'd0);
    chk("dbz_latency", 64'(lat), 64'd2);
    chk("dbz_flag", {63'd0, div_by_zero}, 64'd1);
    chk("dbz_hi", {32'd0, hi}, 64'h64);
    chk("dbz_lo", {32'd0, lo}, 64'hFFFF_FFFF);

    // MTLO clears the flag
    write_reg(3'b101, 32'd5);
    chk("mtlo_lo", {32'd0, lo}, 64'd5);
    chk("mtlo_dbz", {63'd0, div_by_zero}, 64'd0);
    chk("mtlo_busy", {63'd0, busy}, 64'd0);
    chk("mtlo_done", {63'd0, done}, 64'd0);
    chk("mtlo_hi_kept", {32'd0, hi}, 64'h64);

    // Preload, then flush a MULT at iteration 10
    write_reg(3'b100, 32'h11);
    write_reg(3'b101, 32'h22);
    md_op = 3'b000; rs_data = 32'd3; rt_data = 32'h8000_0001; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; md_op = 3'b111;
    repeat (4) begin @(posedge clock); #1; end
    md_op = 3'b100; rs_data = 32'hDEAD; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; md_op = 3'b111;
    chk("busy_start_ignored_hi", {32'd0, hi}, 64'h11);
    chk("busy_still", {63'd0, busy}, 64'd1);
    repeat (4) begin @(posedge clock); #1; end
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_done", {63'd0, done}, 64'd0);
    dcnt = 0;
    repeat (40) begin @(posedge clock); #1; if (done) dcnt++; end
    chk("flush_no_done", 64'(dcnt), 64'd0);
    chk("flush_hi", {32'd0, hi}, 64'h11);
    chk("flush_lo", {32'd0, lo}, 64'h22);

    // flush in IDLE blocks a same-cycle start
    flush = 1'b1;
    write_reg(3'b100, 32'h99);
    flush = 1'b0;
    chk("idle_flush_mthi", {32'd0, hi}, 64'h11);
    chk("idle_flush_busy", {63'd0, busy}, 64'd0);

    // flush on the FIX cycle discards the result
    md_op = 3'b011; rs_data = 32'd9; rt_data = 32'd0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; md_op = 3'b111; flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    chk("fixflush_done", {63'd0, done}, 64'd0);
    chk("fixflush_busy", {63'd0, busy}, 64'd0);
    chk("fixflush_hi", {32'd0, hi}, 64'h11);
    chk("fixflush_lo", {32'd0, lo}, 64'h22);

    // Asynchronous reset in the middle of a DIV
    md_op = 3'b010; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; md_op = 3'b111;
    repeat (5) begin @(posedge clock); #1; end
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_hi", {32'd0, hi}, 64'd0);
    chk("arst_lo", {32'd0, lo}, 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // MULTU 3 x 1
    run_op(3'b001, 32'd3, 32'd1);
`ifdef MULDIV_EARLY_OUT_EN
    chk("early_latency_le4", {63'd0, (lat <= 4)}, 64'd1);
`else
    chk("small_latency", 64'(lat), 64'd34);
`endif
    chk("small_hi", {32'd0, hi}, 64'd0);
    chk("small_lo", {32'd0, lo}, 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_muldiv_unit.md
Name: exec_muldiv_unit

Overview:
Iterative multiply/divide companion to the single-cycle 32-bit ALU in the execute stage. Owns the architectural HI/LO registers and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiply and divide take one bit per cycle, and the block raises busy so the pipeline stalls issue. Operand width is parametrised, so the same block serves the 32-bit core and narrower test configurations.

Parameters:
DATA_W, 32, operand width and HI/LO width; must be even and at least 4.
CNT_W, $clog2(DATA_W)+1, width of the iteration counter; derived, not overridden.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  operation request, sampled only when busy=0.
md_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others are NOP.
rs_data  in  DATA_W  dividend / multiplicand / MTHI-MTLO source.
rt_data  in  DATA_W  divisor / multiplier.
flush  in  1  abort any in-flight operation (branch or exception kill).
busy  out  1  high while MUL or DIV iteration is in progress.
done  out  1  one-cycle pulse when HI/LO take a mult/div result.
div_by_zero  out  1  valid with done; set when a DIV/DIVU had rt_data=0.
hi  out  DATA_W  HI register (MFHI source).
lo  out  DATA_W  LO register (MFLO source).

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; hi=lo=0; busy=0; done=0; div_by_zero=0; counter=0. Reset mid-operation discards the operation.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE + start + MULT/MULTU: latch operand magnitudes (signed ops use two's-complement absolute values), latch the result sign, load counter=DATA_W, go to MUL.
  - IDLE + start + DIV/DIVU: same latching, go to DIV.
  - IDLE + start + MTHI/MTLO: write hi or lo from rs_data at that edge, stay in IDLE, no busy, no done.
  - IDLE + start + NOP code: no effect.
- MUL: shift-add, one multiplier bit per cycle; DATA_W iterations, then FIX.
- DIV: restoring division, one quotient bit per cycle; DATA_W iterations, then FIX.
- FIX: apply signs. Quotient is negated when operand signs differ; remainder takes the dividend's sign. Product is negated when the result sign is negative. Write {hi,lo} (mult) or hi=remainder, lo=quotient (div); pulse done; return to IDLE.
- Latency: busy=1 from the edge after start through FIX inclusive. done is high in the cycle after FIX completes, i.e. start to done = DATA_W+2 edges. done and busy never overlap.
- All arithmetic uses DATA_W bits with modular wrap. Signed DIV of most-negative by -1 gives lo=most-negative, hi=0, and no flag.
- Divide by zero: skip iteration and go straight from IDLE to FIX. Result hi=rs_data, lo=all-ones, div_by_zero=1 with done. The flag clears on the next accepted start.
- start while busy=1 is ignored; no queueing. The pipeline must hold the instruction.
- flush while busy: return to IDLE next edge, hi/lo unchanged, no done. flush in IDLE also blocks a same-cycle start (including MTHI/MTLO).
- flush on the FIX cycle: the result is discarded.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: in MUL, when the remaining unshifted multiplier bits are all zero, jump to FIX immediately. Latency becomes variable, minimum 2 edges for rt_data=0.
- Undefined: fixed latency of DATA_W+2 edges for every mult/div.
- Results are identical in both builds.

Decomposition:
- Shared package exec_pkg: md_op encodings (MD_MULT … MD_MTLO), FSM state enum, default DATA_W.
- One natural sub-module, md_div_step: combinational single restoring-division step mapping (remainder, quotient, divisor) to the next (remainder, quotient). Instantiated once in DIV.
- Multiply step stays inline.

Test Plan:
- MULT rs=0xFFFFFFFD, rt=7 → done at start+34 edges; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly 33 cycles.
- MULTU rs=rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU rs=100, rt=0 → done after 2 edges; div_by_zero=1, hi=0x64, lo=0xFFFFFFFF; next MTLO 5 clears the flag and sets lo=5.
- Preload hi=0x11, lo=0x22; MULT then flush at iteration 10 → busy low next cycle, no done, hi/lo stay 0x11/0x22; start during busy is ignored.
- reset_n low mid-DIV → busy=0, hi=lo=0 immediately, independent of clock; with MULDIV_EARLY_OUT_EN, MULTU 3×1 gives done within 4 edges, hi=0, lo=3.
